// File: rtl/mipi_tx_raw_packer.sv
// RAW10 pixel-group to 4-lane CSI-2 byte packer with end-of-line flush and line byte count.
// Optional build macro MIPI_TX_RAW8_MODE_EN adds raw8_mode_i (4 MSB bytes per group, no LSB byte).
module mipi_tx_raw_packer #(
  parameter int BUF_BYTES = 8,
  parameter int WC_WIDTH  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                pixel_valid_i,
  input  logic [39:0]         pixel_i,
  input  logic                pixel_last_i,
  output logic                pixel_ready_o,
`ifdef MIPI_TX_RAW8_MODE_EN
  input  logic                raw8_mode_i,
`endif
  output logic                data_valid_o,
  output logic [31:0]         data_o,
  output logic                data_last_o,
  input  logic                data_ready_i,
  output logic [WC_WIDTH-1:0] line_bytes_o
);

  localparam int CW = $clog2(BUF_BYTES + 1);

  logic [8*BUF_BYTES-1:0] r_buf, w_buf_nxt, w_buf_shift;
  logic [CW-1:0]          r_cnt, w_pop_n, w_rem, w_cnt_nxt;
  logic                   r_flush, r_valid, r_last;
  logic [31:0]            r_data, w_word;
  logic [WC_WIDTH-1:0]    r_line_cnt, r_line_bytes, w_line_sat;
  logic [WC_WIDTH:0]      w_line_sum;
  logic [39:0]            w_grp;
  logic [2:0]             w_grp_n;
  logic                   w_raw8, w_out_free, w_full_word, w_flush_word;
  logic                   w_load, w_load_last, w_accept, w_ready;

`ifdef MIPI_TX_RAW8_MODE_EN
  logic r_raw8;

  // Mode may only change between lines, i.e. while nothing is buffered or flushing.
  assign w_raw8 = (r_cnt == '0 && !r_flush) ? raw8_mode_i : r_raw8;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_raw8 <= 1'b0;
    else         r_raw8 <= w_raw8;
  end
`else
  assign w_raw8 = 1'b0;
`endif

  // Wire order: byte k of the group sits at w_grp[8k +: 8].
  assign w_grp = {pixel_i[31:30], pixel_i[21:20], pixel_i[11:10], pixel_i[1:0],
                  pixel_i[9:2], pixel_i[19:12], pixel_i[29:22], pixel_i[39:32]};
  assign w_grp_n = w_raw8 ? 3'd4 : 3'd5;

  assign w_out_free   = !r_valid || data_ready_i;
  assign w_full_word  = r_cnt >= CW'(4);
  assign w_flush_word = r_flush && (r_cnt != '0) && !w_full_word;
  assign w_load       = w_out_free && (w_full_word || w_flush_word);
  assign w_load_last  = r_flush && (w_flush_word || r_cnt == CW'(4));
  assign w_pop_n      = !w_load ? '0 : (w_full_word ? CW'(4) : r_cnt);
  assign w_rem        = r_cnt - w_pop_n;
  assign w_ready      = !r_flush && (int'(w_rem) + int'(w_grp_n) <= BUF_BYTES);
  assign w_accept     = pixel_valid_i && w_ready;
  assign w_cnt_nxt    = w_rem + (w_accept ? CW'(w_grp_n) : CW'(0));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_word = '0;
    for (int b = 0; b < 4; b++)
      if (b < int'(r_cnt)) w_word[8*b +: 8] = r_buf[8*b +: 8];
  end

  assign w_buf_shift = r_buf >> (8 * w_pop_n);

  always_comb begin
    w_buf_nxt = w_buf_shift;
    for (int i = 0; i < BUF_BYTES; i++)
      for (int k = 0; k < 5; k++)
        if (w_accept && k < int'(w_grp_n) && i == int'(w_rem) + k)
          w_buf_nxt[8*i +: 8] = w_grp[8*k +: 8];
  end

  assign w_line_sum = {1'b0, r_line_cnt} + (WC_WIDTH+1)'(w_grp_n);
  assign w_line_sat = w_line_sum[WC_WIDTH] ? '1 : w_line_sum[WC_WIDTH-1:0];

  // NOTE: the byte store is pure data qualified by r_cnt, so it carries no reset.
  always_ff @(posedge clk_i) begin
    r_buf <= w_buf_nxt;
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt        <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_flush      <= 1'b0;
      r_line_cnt   <= '0;
      r_line_bytes <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_last  <= w_load_last;
      end else if (data_ready_i) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (w_accept && pixel_last_i)
        r_flush <= 1'b1;
      else if (r_valid && r_last && data_ready_i)
        r_flush <= 1'b0;
      if (w_accept) begin
        if (pixel_last_i) begin
          r_line_bytes <= w_line_sat;
          r_line_cnt   <= '0;
        end else begin
          r_line_cnt   <= w_line_sat;
        end
      end
    end
  end

  assign pixel_ready_o = w_ready;
  assign data_valid_o  = r_valid;
  assign data_o        = r_data;
  assign data_last_o   = r_last;
  assign line_bytes_o  = r_line_bytes;

endmodule

// File: tb/tb_mipi_tx_raw_packer.sv
// Self-checking bench for mipi_tx_raw_packer: random pixel groups against a byte-stream reference model.
// Build with MIPI_TX_RAW8_MODE_EN defined to also exercise the RAW8 path.
module tb_mipi_tx_raw_packer;
  localparam int BUF_BYTES = 8;
  localparam int WC_WIDTH  = 16;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                pixel_valid_i, pixel_last_i, data_ready_i;
  logic [39:0]         pixel_i;
  logic                pixel_ready_o, data_valid_o, data_last_o;
  logic [31:0]         data_o;
  logic [WC_WIDTH-1:0] line_bytes_o;
  bit                  raw8_sel;

`ifdef MIPI_TX_RAW8_MODE_EN
  logic raw8_mode_i;
  assign raw8_mode_i = raw8_sel;
`endif

  mipi_tx_raw_packer #(.BUF_BYTES(BUF_BYTES), .WC_WIDTH(WC_WIDTH)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .pixel_valid_i (pixel_valid_i),
    .pixel_i       (pixel_i),
    .pixel_last_i  (pixel_last_i),
    .pixel_ready_o (pixel_ready_o),
`ifdef MIPI_TX_RAW8_MODE_EN
    .raw8_mode_i   (raw8_mode_i),
`endif
    .data_valid_o  (data_valid_o),
    .data_o        (data_o),
    .data_last_o   (data_last_o),
    .data_ready_i  (data_ready_i),
    .line_bytes_o  (line_bytes_o)
  );

  always #5 clk = ~clk;

  int checks, errors;
  int rdy_mode;
  int cyc, acc_groups, first_rx, last_rx;

  // Reference model: bytes of the current line, then chunked into 4-byte words at line end.
  logic [7:0]          line_q[$];
  int unsigned         line_cnt;
  logic [31:0]         exp_words[$];
  bit                  exp_lasts[$];
  logic [WC_WIDTH-1:0] exp_line_bytes;
  logic [31:0]         rx_words[$];
  bit                  rx_lasts[$];
  bit                  prev_stall;
  logic [31:0]         prev_word;
  logic                prev_last;

  task automatic model_accept(input logic [39:0] pix, input logic last, input bit raw8);
    logic [9:0]  p [4];
    logic [31:0] w;
    for (int k = 0; k < 4; k++) p[k] = pix[39-10*k -: 10];
    for (int k = 0; k < 4; k++) line_q.push_back(p[k][9:2]);
    if (!raw8) line_q.push_back({p[0][1:0], p[1][1:0], p[2][1:0], p[3][1:0]});
    line_cnt = line_cnt + (raw8 ? 4 : 5);
    if (line_cnt > (1 << WC_WIDTH) - 1) line_cnt = (1 << WC_WIDTH) - 1;
    if (last) begin
      exp_line_bytes = line_cnt[WC_WIDTH-1:0];
      line_cnt = 0;
      while (line_q.size() > 0) begin
        w = '0;
        for (int b = 0; b < 4; b++)
          if (line_q.size() > 0) w[8*b +: 8] = line_q.pop_front();
        exp_words.push_back(w);
        exp_lasts.push_back(line_q.size() == 0);
      end
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    line_cnt = 0;
    exp_words.delete();
    exp_lasts.delete();
    rx_words.delete();
    rx_lasts.delete();
    exp_line_bytes = '0;
    prev_stall = 1'b0;
  endtask

  // Monitor: inputs change at posedge+1, so negedge values are what the next edge acts on.
  always @(negedge clk) begin
    cyc++;
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (data_valid_o !== 1'b1 || data_o !== prev_word || data_last_o !== prev_last) begin
          errors++;
          $display("FAIL hold_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   data_valid_o, data_o, data_last_o, prev_word, prev_last);
        end
      end
      if (pixel_valid_i && pixel_ready_o) begin
        acc_groups++;
        model_accept(pixel_i, pixel_last_i, raw8_sel);
      end
      if (data_valid_o && data_ready_i) begin
        rx_words.push_back(data_o);
        rx_lasts.push_back(data_last_o);
        if (first_rx < 0) first_rx = cyc;
        last_rx = cyc;
      end
      prev_stall = data_valid_o && !data_ready_i;
      prev_word  = data_o;
      prev_last  = data_last_o;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0)      data_ready_i = 1'b0;
    else if (rdy_mode == 1) data_ready_i = 1'b1;
    else                    data_ready_i = 1'($urandom_range(0, 1));
  end

  task automatic drive_group(input logic [39:0] pix, input logic last, output int stalls);
    int n = 0;
    bit acc = 0;
    pixel_valid_i = 1'b1;
    pixel_i = pix;
    pixel_last_i = last;
    stalls = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = pixel_ready_o;
      @(posedge clk); #1;
      if (!acc) stalls++;
      n++;
    end
    pixel_valid_i = 1'b0;
    pixel_last_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: group %h not accepted in %0d cycles, required accept", pix, n);
    end
  endtask

  task automatic send_line(input int n, input bit gaps, input bit with_last, output int stalls);
    int s;
    logic [63:0] r;
    stalls = 0;
    for (int g = 0; g < n; g++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      r = {$urandom(), $urandom()};
      drive_group(r[39:0], with_last && (g == n - 1), s);
      stalls += s;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((rx_words.size() < exp_words.size() || data_valid_o) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s drain_timeout: got %0d words, required %0d", name, rx_words.size(), exp_words.size());
    end
  endtask

  task automatic compare_stream(input string name);
    int n;
    checks++;
    if (rx_words.size() != exp_words.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d, required %0d", name, rx_words.size(), exp_words.size());
    end
    n = (rx_words.size() < exp_words.size()) ? rx_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_words[i] !== exp_words[i] || rx_lasts[i] !== exp_lasts[i]) begin
        errors++;
        $display("FAIL %s word[%0d]: got %h last=%b, required %h last=%b",
                 name, i, rx_words[i], rx_lasts[i], exp_words[i], exp_lasts[i]);
      end
    end
    checks++;
    if (line_bytes_o !== exp_line_bytes) begin
      errors++;
      $display("FAIL %s line_bytes: got %0d, required %0d", name, line_bytes_o, exp_line_bytes);
    end
    rx_words.delete();
    rx_lasts.delete();
    exp_words.delete();
    exp_lasts.delete();
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_val({name, "_valid"}, 32'(data_valid_o), 32'd0);
    check_val({name, "_data"}, data_o, 32'd0);
    check_val({name, "_last"}, 32'(data_last_o), 32'd0);
    check_val({name, "_line_bytes"}, 32'(line_bytes_o), 32'd0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_i = 1'b0;
    @(negedge clk);
    check_val("reset_ready", 32'(pixel_ready_o), 32'd1);
    @(posedge clk); #1;
    rdy_mode = 1;
    data_ready_i = 1'b1;
  endtask

  task automatic test_single_group();
    int s;
    @(posedge clk); #1;
    drive_group({10'h3FF, 10'h000, 10'h2AA, 10'h155}, 1'b1, s);
    wait_drain("single");
    check_val("single_count", 32'(rx_words.size()), 32'd2);
    if (rx_words.size() > 0) check_val("single_word0", rx_words[0], 32'h55AA00FF);
    check_val("single_line_bytes", 32'(line_bytes_o), 32'd5);
    compare_stream("single");
  endtask

  task automatic test_back_to_back();
    int s;
    @(posedge clk); #1;
    first_rx = -1;
    send_line(4, 1'b0, 1'b1, s);
    wait_drain("b2b4");
    check_val("b2b4_stalls", 32'(s), 32'd0);
    check_val("b2b4_count", 32'(rx_words.size()), 32'd5);
    check_val("b2b4_no_gaps", 32'(last_rx - first_rx + 1), 32'(rx_words.size()));
    check_val("b2b4_line_bytes", 32'(line_bytes_o), 32'd20);
    compare_stream("b2b4");
    @(posedge clk); #1;
    first_rx = -1;
    send_line(8, 1'b0, 1'b1, s);
    wait_drain("b2b8");
    check_val("b2b8_stalls", 32'(s), 32'd1);
    check_val("b2b8_no_gaps", 32'(last_rx - first_rx + 1), 32'(rx_words.size()));
    compare_stream("b2b8");
  endtask

  task automatic test_random_line();
    int s;
    @(posedge clk); #1;
    rdy_mode = 2;
    send_line(160, 1'b1, 1'b1, s);
    wait_drain("random");
    check_val("random_count", 32'(rx_words.size()), 32'd200);
    check_val("random_line_bytes", 32'(line_bytes_o), 32'd800);
    compare_stream("random");
    rdy_mode = 1;
  endtask

  task automatic test_stall();
    int s;
    @(posedge clk); #1;
    rdy_mode = 0;
    data_ready_i = 1'b0;
    acc_groups = 0;
    fork
      send_line(6, 1'b0, 1'b1, s);
      begin
        repeat (20) @(posedge clk);
        #1;
        check_val("stall_accepted", 32'(acc_groups), 32'd2);
        check_val("stall_ready", 32'(pixel_ready_o), 32'd0);
        check_val("stall_valid", 32'(data_valid_o), 32'd1);
        rdy_mode = 1;
        data_ready_i = 1'b1;
      end
    join
    wait_drain("stall");
    check_val("stall_count", 32'(rx_words.size()), 32'd8);
    compare_stream("stall");
  endtask

`ifdef MIPI_TX_RAW8_MODE_EN
  task automatic test_raw8();
    int s;
    @(posedge clk); #1;
    raw8_sel = 1'b1;
    @(posedge clk); #1;
    send_line(3, 1'b0, 1'b1, s);
    wait_drain("raw8");
    check_val("raw8_count", 32'(rx_words.size()), 32'd3);
    check_val("raw8_line_bytes", 32'(line_bytes_o), 32'd12);
    compare_stream("raw8");
    raw8_sel = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid_line();
    int s;
    @(posedge clk); #1;
    send_line(3, 1'b0, 1'b0, s);
    @(posedge clk);
    #3;
    reset_i = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    reset_i = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("midreset_ready", 32'(pixel_ready_o), 32'd1);
    @(posedge clk); #1;
    send_line(2, 1'b0, 1'b0, s);
    check_val("midreset_partial_line_bytes", 32'(line_bytes_o), 32'd0);
    send_line(1, 1'b0, 1'b1, s);
    wait_drain("midreset");
    check_val("midreset_line_bytes", 32'(line_bytes_o), 32'd15);
    compare_stream("midreset");
  endtask

  initial begin
    reset_i = 1'b1;
    pixel_valid_i = 1'b0;
    pixel_i = '0;
    pixel_last_i = 1'b0;
    data_ready_i = 1'b0;
    rdy_mode = 0;
    raw8_sel = 1'b0;
    checks = 0;
    errors = 0;
    cyc = 0;
    acc_groups = 0;
    first_rx = -1;
    last_rx = -1;
    model_reset();
    test_reset();
    test_single_group();
    test_back_to_back();
    test_random_line();
    test_stall();
`ifdef MIPI_TX_RAW8_MODE_EN
    test_raw8();
`endif
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
